// File: rtl/usr_pkg.sv
// usr_pkg: mode encodings and sequencer states shared by the universal shift engine
package usr_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} usr_state_t;
endpackage

// File: rtl/usr_shift_engine_if.sv
// usr_shift_engine_if: control/data bundle (mode, serial ins, pdin, burst request in; pdout, serial outs, busy/done out)
interface usr_shift_engine_if #(parameter int WIDTH = 8, parameter int CNT_W = 4);
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pdin;
  logic             start;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] pdout;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;
  modport master (output mode, sin_r, sin_l, pdin, start, shift_cnt, input pdout, sout_r, sout_l, busy, done);
  modport slave  (input mode, sin_r, sin_l, pdin, start, shift_cnt, output pdout, sout_r, sout_l, busy, done);
endinterface

// File: rtl/usr_bit_cell.sv
// usr_bit_cell: one register bit; sel 00 hold, 01 r_in, 10 l_in, 11 d, sync reset rst clears q
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       r_in,
  input  logic       l_in,
  input  logic       d,
  output logic       q
);
  logic nxt;
  always_comb nxt = sel == MODE_SHR ? r_in : sel == MODE_SHL ? l_in : sel == MODE_LOAD ? d : q;
  always_ff @(posedge clk)
    if (rst) q <= 1'b0;
    else q <= nxt;
endmodule

// File: rtl/usr_shift_engine.sv
// usr_shift_engine: universal shift register with N-shift burst sequencer; clk, rst, bus (slave) carries mode/serial/parallel/burst I/O
module usr_shift_engine
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               rst,
  usr_shift_engine_if.slave bus
);
  usr_state_t       state, state_n;
  logic             dir_l, dir_l_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [1:0]       sel;
  logic             accept;
  logic [WIDTH-1:0] q, rn, ln;
  assign rn = {bus.sin_r, q[WIDTH-1:1]};
  assign ln = {q[WIDTH-2:0], bus.sin_l};
  always_comb begin
    accept  = state == IDLE && bus.start && (bus.mode == MODE_SHR || bus.mode == MODE_SHL);
    sel     = state == SHIFT ? (dir_l ? MODE_SHL : MODE_SHR) :
              state == DONE ? MODE_HOLD :
              accept && bus.shift_cnt == '0 ? MODE_HOLD : bus.mode;
    dir_l_n = accept ? bus.mode == MODE_SHL : dir_l;
    rem_n   = accept ? (bus.shift_cnt == '0 ? '0 : bus.shift_cnt - CNT_W'(1)) :
              state == SHIFT && rem != '0 ? rem - CNT_W'(1) : rem;
    state_n = state == IDLE ? (accept ? (bus.shift_cnt > CNT_W'(1) ? SHIFT : DONE) : IDLE) :
              state == SHIFT ? (rem <= CNT_W'(1) ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      dir_l <= 1'b0;
      rem   <= '0;
    end else begin
      state <= state_n;
      dir_l <= dir_l_n;
      rem   <= rem_n;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .sel  (sel),
      .r_in (rn[i]),
      .l_in (ln[i]),
      .d    (bus.pdin[i]),
      .q    (q[i])
    );
  end
  assign bus.pdout  = q;
  assign bus.sout_r = q[0];
  assign bus.sout_l = q[WIDTH-1];
  assign bus.busy   = state != IDLE;
  assign bus.done   = state == DONE;
endmodule

// File: tb/tb_usr_shift_engine.sv
// tb_usr_shift_engine: directed checks of reset, direct ops, bursts and mid-burst reset
module tb_usr_shift_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  usr_shift_engine_if #(.WIDTH(8), .CNT_W(4)) bus ();
  usr_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_st(input string tag, input logic [7:0] p, input logic b, input logic d);
    chk({tag, "_pdout"}, bus.pdout, p);
    chk({tag, "_busy"}, {7'd0, bus.busy}, {7'd0, b});
    chk({tag, "_done"}, {7'd0, bus.done}, {7'd0, d});
  endtask
  initial begin
    bus.mode = 2'($urandom);
    bus.sin_r = 1'($urandom);
    bus.sin_l = 1'($urandom);
    bus.pdin = 8'($urandom);
    bus.start = 1'b1;
    bus.shift_cnt = 4'($urandom);
    step();
    bus.mode = 2'($urandom);
    bus.pdin = 8'($urandom);
    step();
    chk_st("reset", 8'h00, 1'b0, 1'b0);
    chk("reset_sout_r", {7'd0, bus.sout_r}, 8'h00);
    chk("reset_sout_l", {7'd0, bus.sout_l}, 8'h00);
    rst = 1'b0;
    bus.start = 1'b0;
    bus.mode = 2'b11;
    bus.pdin = 8'hA5;
    step();
    chk("load_a5", bus.pdout, 8'hA5);
    bus.mode = 2'b00;
    step();
    chk("hold1", bus.pdout, 8'hA5);
    step();
    chk("hold2", bus.pdout, 8'hA5);
    step();
    chk("hold3", bus.pdout, 8'hA5);
    bus.mode = 2'b11;
    bus.pdin = 8'h81;
    step();
    chk("load_81", bus.pdout, 8'h81);
    chk("load_81_sout_r", {7'd0, bus.sout_r}, 8'h01);
    chk("load_81_sout_l", {7'd0, bus.sout_l}, 8'h01);
    bus.mode = 2'b01;
    bus.sin_r = 1'b0;
    step();
    chk("shr1", bus.pdout, 8'h40);
    chk("shr1_sout_r", {7'd0, bus.sout_r}, 8'h00);
    step();
    chk("shr2", bus.pdout, 8'h20);
    bus.mode = 2'b11;
    bus.pdin = 8'h01;
    step();
    chk("load_01", bus.pdout, 8'h01);
    bus.mode = 2'b10;
    bus.sin_l = 1'b1;
    bus.start = 1'b1;
    bus.shift_cnt = 4'd3;
    step();
    chk_st("burst_l1", 8'h03, 1'b1, 1'b0);
    bus.start = 1'b0;
    bus.mode = 2'b11;
    bus.pdin = 8'hFF;
    step();
    chk_st("burst_l2", 8'h07, 1'b1, 1'b0);
    step();
    chk_st("burst_l3", 8'h0F, 1'b1, 1'b1);
    bus.mode = 2'b00;
    step();
    chk_st("burst_l_idle", 8'h0F, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.mode = 2'b01;
    bus.shift_cnt = 4'd0;
    step();
    chk_st("zero_cnt", 8'h0F, 1'b1, 1'b1);
    bus.shift_cnt = 4'd5;
    step();
    chk_st("start_in_done", 8'h0F, 1'b0, 1'b0);
    bus.start = 1'b0;
    bus.mode = 2'b11;
    bus.pdin = 8'hFF;
    step();
    chk("load_ff", bus.pdout, 8'hFF);
    bus.mode = 2'b01;
    bus.sin_r = 1'b0;
    bus.start = 1'b1;
    bus.shift_cnt = 4'd10;
    step();
    chk_st("burst_r1", 8'h7F, 1'b1, 1'b0);
    bus.start = 1'b0;
    bus.mode = 2'b00;
    step();
    chk("burst_r2", bus.pdout, 8'h3F);
    step();
    chk("burst_r3", bus.pdout, 8'h1F);
    step();
    chk_st("burst_r4", 8'h0F, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk_st("mid_reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_st("after_reset", 8'h00, 1'b0, 1'b0);
    bus.mode = 2'b11;
    bus.pdin = 8'h3C;
    step();
    chk_st("load_3c", 8'h3C, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usr_shift_engine.md
Name: usr_shift_engine

Overview:
- Parameterised universal shift register. Each bit is a mux-fed, synchronously reset flop.
- Modes: hold, shift right, shift left, parallel load.
- Adds a burst sequencer: one start request performs N consecutive shifts, with busy/done handshake.
- Consumes the per-bit flop stage and is the register core that feeds top-level user I/O.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of shift_cnt; bursts of up to 2^CNT_W-1 shifts.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  in  1  serial input entering MSB on shift right.
- sin_l  in  1  serial input entering LSB on shift left.
- pdin  in  WIDTH  parallel load data.
- start  in  1  burst request, valid only with mode 01/10.
- shift_cnt  in  CNT_W  number of shifts in burst.
- pdout  out  WIDTH  register contents (q).
- sout_r  out  1  q[0], combinational from q.
- sout_l  out  1  q[WIDTH-1], combinational from q.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle burst completion pulse.

Behaviour:
- Reset: rst sampled high at an edge gives q=0, state=IDLE, latched dir/count=0, busy=0, done=0. Reset wins over all inputs, including mid-burst; the burst is abandoned and no done is issued.
- Operations on each edge:
  - Shift right: q <= {sin_r, q[WIDTH-1:1]}.
  - Shift left: q <= {q[WIDTH-2:0], sin_l}.
  - Load: q <= pdin.
  - Hold: q unchanged.
- States: IDLE, SHIFT, DONE.
- IDLE, start=0: mode is applied directly every edge, one operation per edge.
- IDLE, start=1, mode 01/10, shift_cnt=N>=1:
  - The first shift is performed on the accepting edge.
  - Direction is latched and remaining is set to N-1.
  - Next state is SHIFT if N>1, else DONE.
- IDLE, start=1, mode 01/10, shift_cnt=0: no shift; next state DONE.
- IDLE, start=1, mode 00/11: start is ignored and the mode is applied as a direct operation.
- SHIFT:
  - Shifts in the latched direction every edge; remaining decrements.
  - Moves to DONE on the edge where remaining goes 1->0.
  - mode, start and pdin are ignored.
  - sin_r/sin_l are sampled live each edge.
- DONE: q holds; done=1 for exactly this cycle; returns to IDLE on the next edge. mode and start are ignored.
- Timing: N shifts occupy edges k..k+N-1 (k = accepting edge). busy=1 from after edge k until the edge ending DONE, i.e. N cycles. done is high in the cycle after edge k+N-1. The next start is accepted on the edge after done.
- No arithmetic wrap: remaining is only decremented when nonzero.
- busy, done and pdout are registered or decoded from registered state; sout_* are combinational from q.

Decomposition:
- Package usr_pkg:
  - mode encodings MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD.
  - state enum usr_state_t {IDLE, SHIFT, DONE}.
- Sub-module usr_bit_cell: per-bit 4:1 operation mux (hold / right neighbour / left neighbour / pdin bit) plus synchronous-reset flop.
  - The top level instantiates WIDTH cells and the sequencer FSM.
  - During SHIFT/DONE the sequencer overrides the cell mux select.

Test Plan (WIDTH=8, CNT_W=4):
1. rst=1 for 2 cycles with random inputs -> pdout=0x00, busy=0, done=0, sout_r=0, sout_l=0.
2. mode=11, pdin=0xA5, one edge; then mode=00 for 3 edges -> pdout=0xA5 throughout hold.
3. Load 0x81; mode=01, sin_r=0 for 2 edges -> pdout 0x40 then 0x20. sout_r: 1 after load, 0 after the first shift.
4. Load 0x01; mode=10, sin_l=1, start=1, shift_cnt=3 for one cycle; then mode=11, pdin=0xFF -> pdout 0x03, 0x07, 0x0F on consecutive edges, busy high 3 cycles, done pulses once, and the load is ignored during the burst.
5. start=1, mode=01, shift_cnt=0 -> pdout unchanged, busy and done high one cycle. start reasserted while busy -> ignored.
6. Burst with shift_cnt=10 from 0xFF, mode=01, sin_r=0; rst=1 after 4 shifts -> pdout=0x00, busy=0, no done. A subsequent direct load of 0x3C succeeds.
